// File: rtl/spc700_io_regs_if.sv
// CPU-side bus of the SPC700 I/O window: address, write data and strobes in,
// combinational read data and window select out.
interface spc700_io_regs_if;
    logic        ce;
    logic [15:0] a_in;
    logic [7:0]  d_in;
    logic        we_n;
    logic [7:0]  d_out;
    logic        sel;

    modport master (
        output ce,
        output a_in,
        output d_in,
        output we_n,
        input  d_out,
        input  sel
    );

    modport slave (
        input  ce,
        input  a_in,
        input  d_in,
        input  we_n,
        output d_out,
        output sel
    );
endinterface

// File: rtl/spc700_io_regs.sv
// SPC700 $00F0-$00FF I/O responder: control, DSP passthrough, host mailbox,
// scratch registers and three interval timers with read-to-clear outputs.
module spc700_io_regs #(
    parameter int T01_DIV = 128,
    parameter int T2_DIV  = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    spc700_io_regs_if.slave bus,
    output logic            ipl_en,
    output logic [7:0]      dsp_addr,
    output logic [7:0]      dsp_do,
    output logic            dsp_we,
    input  logic [7:0]      dsp_di,
    input  logic [1:0]      host_addr,
    input  logic            host_wr,
    input  logic [7:0]      host_din,
    output logic [7:0]      host_dout
);

    localparam int P01_W = (T01_DIV > 1) ? $clog2(T01_DIV) : 1;
    localparam int P2_W  = (T2_DIV > 1) ? $clog2(T2_DIV) : 1;
    localparam logic [P01_W-1:0] P01_LAST = P01_W'(T01_DIV - 1);
    localparam logic [P2_W-1:0]  P2_LAST  = P2_W'(T2_DIV - 1);

    logic [7:0]      test_q, test_d;
    logic [7:0]      control_q, control_d;
    logic [7:0]      dsp_addr_q, dsp_addr_d;
    logic [7:0]      dsp_do_q, dsp_do_d;
    logic            dsp_we_q, dsp_we_d;
    logic [3:0][7:0] in_port_q, in_port_d;
    logic [3:0][7:0] out_port_q, out_port_d;
    logic [1:0][7:0] scratch_q, scratch_d;
    logic [2:0][7:0] target_q, target_d;
    logic [2:0][7:0] stage_q, stage_d;
    logic [2:0][3:0] cnt_q, cnt_d;
    logic [P01_W-1:0] presc01_q, presc01_d;
    logic [P2_W-1:0]  presc2_q, presc2_d;

    logic            sel;
    logic            acc;
    logic            wr;
    logic            rd;
    logic            wr_ctrl;
    logic [3:0]      reg_idx;
    logic            tick01;
    logic            tick2;
    logic [2:0]      tick;
    logic [2:0]      en_rise;
    logic [2:0]      hit;
    logic [2:0]      rd_cnt;
    logic [2:0][7:0] stage_inc;
    logic [7:0]      rdata;
    logic            unused_bits;

    // ---------------------------------------------------------------
    // Address decode
    // ---------------------------------------------------------------
    assign sel     = (bus.a_in[15:4] == 12'h00F);
    assign acc     = bus.ce & sel;
    assign wr      = acc & ~bus.we_n;
    assign rd      = acc & bus.we_n;
    assign reg_idx = bus.a_in[3:0];
    assign wr_ctrl = wr & (reg_idx == 4'h1);
    assign rd_cnt  = {rd & (reg_idx == 4'hF),
                      rd & (reg_idx == 4'hE),
                      rd & (reg_idx == 4'hD)};

    assign bus.sel = sel;

    always_comb begin
        rdata = 8'h00;
        if (sel) begin
            case (reg_idx)
                4'h2:    rdata = dsp_addr_q;
                4'h3:    rdata = dsp_di;
                4'h4,
                4'h5,
                4'h6,
                4'h7:    rdata = in_port_q[reg_idx[1:0]];
                4'h8,
                4'h9:    rdata = scratch_q[reg_idx[0]];
                4'hD:    rdata = {4'h0, cnt_q[0]};
                4'hE:    rdata = {4'h0, cnt_q[1]};
                4'hF:    rdata = {4'h0, cnt_q[2]};
                default: rdata = 8'h00;
            endcase
        end
    end

    assign bus.d_out = rdata;

    // ---------------------------------------------------------------
    // Free-running prescalers: down-counters that tick on the CE that
    // finds them at zero, so the first tick lands on the DIV-th CE.
    // ---------------------------------------------------------------
    assign tick01 = bus.ce & (presc01_q == '0);
    assign tick2  = bus.ce & (presc2_q == '0);
    assign tick   = {tick2, tick01, tick01};

    always_comb begin
        presc01_d = presc01_q;
        presc2_d  = presc2_q;
        if (bus.ce) begin
            presc01_d = (presc01_q == '0) ? P01_LAST : presc01_q - 1'b1;
            presc2_d  = (presc2_q == '0) ? P2_LAST : presc2_q - 1'b1;
        end
    end

    // ---------------------------------------------------------------
    // Timer stage and output counters
    // ---------------------------------------------------------------
    always_comb begin
        for (int n = 0; n < 3; n++) begin
            stage_inc[n] = stage_q[n] + 8'd1;
            en_rise[n]   = wr_ctrl & bus.d_in[n] & ~control_q[n];
            hit[n]       = tick[n] & control_q[n] & (stage_inc[n] == target_q[n]);
        end
    end

    // An enabling write beats a coincident tick; a read-clear that meets an
    // increment leaves the counter at 1 so the new event is not lost.
    always_comb begin
        stage_d = stage_q;
        cnt_d   = cnt_q;
        for (int n = 0; n < 3; n++) begin
            if (en_rise[n]) begin
                stage_d[n] = 8'h00;
                cnt_d[n]   = 4'h0;
            end else if (tick[n] & control_q[n]) begin
                stage_d[n] = hit[n] ? 8'h00 : stage_inc[n];
                if (hit[n]) begin
                    cnt_d[n] = cnt_q[n] + 4'h1;
                end
            end
            if (rd_cnt[n]) begin
                cnt_d[n] = {3'b000, hit[n]};
            end
        end
    end

    // ---------------------------------------------------------------
    // Register file writes and host mailbox
    // ---------------------------------------------------------------
    always_comb begin
        test_d     = test_q;
        control_d  = control_q;
        dsp_addr_d = dsp_addr_q;
        dsp_do_d   = dsp_do_q;
        out_port_d = out_port_q;
        scratch_d  = scratch_q;
        target_d   = target_q;
        dsp_we_d   = wr & (reg_idx == 4'h3);
        if (wr) begin
            case (reg_idx)
                4'h0:    test_d     = bus.d_in;
                4'h1:    control_d  = bus.d_in;
                4'h2:    dsp_addr_d = bus.d_in;
                4'h3:    dsp_do_d   = bus.d_in;
                4'h4,
                4'h5,
                4'h6,
                4'h7:    out_port_d[reg_idx[1:0]] = bus.d_in;
                4'h8,
                4'h9:    scratch_d[reg_idx[0]] = bus.d_in;
                4'hA:    target_d[0] = bus.d_in;
                4'hB:    target_d[1] = bus.d_in;
                4'hC:    target_d[2] = bus.d_in;
                default: ;
            endcase
        end
    end

    // Host write is applied last so it wins over a CONTROL port clear.
    always_comb begin
        in_port_d = in_port_q;
        if (wr_ctrl & bus.d_in[4]) begin
            in_port_d[0] = 8'h00;
            in_port_d[1] = 8'h00;
        end
        if (wr_ctrl & bus.d_in[5]) begin
            in_port_d[2] = 8'h00;
            in_port_d[3] = 8'h00;
        end
        if (host_wr) begin
            in_port_d[host_addr] = host_din;
        end
    end

    // ---------------------------------------------------------------
    // State
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            test_q     <= 8'h0A;
            control_q  <= 8'hB0;
            dsp_addr_q <= 8'h00;
            dsp_do_q   <= 8'h00;
            dsp_we_q   <= 1'b0;
            in_port_q  <= '0;
            out_port_q <= '0;
            scratch_q  <= '0;
            target_q   <= '0;
            stage_q    <= '0;
            cnt_q      <= '0;
            presc01_q  <= P01_LAST;
            presc2_q   <= P2_LAST;
        end else begin
            test_q     <= test_d;
            control_q  <= control_d;
            dsp_addr_q <= dsp_addr_d;
            dsp_do_q   <= dsp_do_d;
            dsp_we_q   <= dsp_we_d;
            in_port_q  <= in_port_d;
            out_port_q <= out_port_d;
            scratch_q  <= scratch_d;
            target_q   <= target_d;
            stage_q    <= stage_d;
            cnt_q      <= cnt_d;
            presc01_q  <= presc01_d;
            presc2_q   <= presc2_d;
        end
    end

    assign ipl_en    = control_q[7];
    assign dsp_addr  = dsp_addr_q;
    assign dsp_do    = dsp_do_q;
    assign dsp_we    = dsp_we_q;
    assign host_dout = out_port_q[host_addr];

    // TEST and the spare CONTROL bits are stored but drive nothing.
    assign unused_bits = ^{test_q, control_q[6:3]};

endmodule

// File: tb/tb_spc700_io_regs.sv
// Directed plus randomized bench for spc700_io_regs against a behavioural
// model of the register map and timers.
module tb_spc700_io_regs;
    localparam int T01 = 128;
    localparam int T2  = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ipl_en;
    logic [7:0] dsp_addr;
    logic [7:0] dsp_do;
    logic       dsp_we;
    logic [7:0] dsp_di;
    logic [1:0] host_addr;
    logic       host_wr;
    logic [7:0] host_din;
    logic [7:0] host_dout;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    spc700_io_regs_if bus ();

    spc700_io_regs #(.T01_DIV(T01), .T2_DIV(T2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .ipl_en    (ipl_en),
        .dsp_addr  (dsp_addr),
        .dsp_do    (dsp_do),
        .dsp_we    (dsp_we),
        .dsp_di    (dsp_di),
        .host_addr (host_addr),
        .host_wr   (host_wr),
        .host_din  (host_din),
        .host_dout (host_dout)
    );

    // Behavioural model state
    int         m_ce;
    logic [7:0] m_ctrl;
    logic [7:0] m_dsp_addr;
    logic [7:0] m_dsp_do;
    logic       m_dsp_we;
    logic [7:0] m_in [4];
    logic [7:0] m_out [4];
    logic [7:0] m_scr [2];
    int         m_target [3];
    int         m_stage [3];
    int         m_cnt [3];

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        m_ce = 0;
        m_ctrl = 8'hB0;
        m_dsp_addr = 8'h00;
        m_dsp_do = 8'h00;
        m_dsp_we = 1'b0;
        for (int i = 0; i < 4; i++) begin
            m_in[i] = 8'h00;
            m_out[i] = 8'h00;
        end
        m_scr[0] = 8'h00;
        m_scr[1] = 8'h00;
        for (int i = 0; i < 3; i++) begin
            m_target[i] = 256;
            m_stage[i] = 0;
            m_cnt[i] = 0;
        end
    endtask

    function automatic logic [7:0] m_read(input logic [15:0] a, input logic [7:0] di);
        int r;
        if (a[15:4] != 12'h00F) return 8'h00;
        r = int'(a[3:0]);
        if (r == 2) return m_dsp_addr;
        if (r == 3) return di;
        if (r >= 4 && r <= 7) return m_in[r-4];
        if (r == 8 || r == 9) return m_scr[r-8];
        if (r >= 13) return 8'(m_cnt[r-13]);
        return 8'h00;
    endfunction

    task automatic model_edge(input logic ce, input logic [15:0] a, input logic [7:0] d,
                              input logic we_n, input logic hw, input logic [1:0] ha,
                              input logic [7:0] hd);
        logic acc, wr, rd, tk, inc;
        int   r, div;
        acc = ce && (a[15:4] == 12'h00F);
        wr  = acc && !we_n;
        rd  = acc && we_n;
        r   = int'(a[3:0]);
        for (int n = 0; n < 3; n++) begin
            div = (n == 2) ? T2 : T01;
            tk  = ce && (((m_ce + 1) % div) == 0);
            inc = 1'b0;
            if (wr && r == 1 && d[n] && !m_ctrl[n]) begin
                m_stage[n] = 0;
                m_cnt[n] = 0;
            end else if (m_ctrl[n] && tk) begin
                m_stage[n] = (m_stage[n] + 1) % 256;
                if (m_stage[n] == m_target[n] % 256) begin
                    m_stage[n] = 0;
                    m_cnt[n] = (m_cnt[n] + 1) % 16;
                    inc = 1'b1;
                end
            end
            if (rd && r == 13 + n) m_cnt[n] = inc ? 1 : 0;
        end
        if (ce) m_ce++;
        m_dsp_we = wr && r == 3;
        if (wr) begin
            if (r == 1) begin
                m_ctrl = d;
                if (d[4]) begin m_in[0] = 8'h00; m_in[1] = 8'h00; end
                if (d[5]) begin m_in[2] = 8'h00; m_in[3] = 8'h00; end
            end
            if (r == 2) m_dsp_addr = d;
            if (r == 3) m_dsp_do = d;
            if (r >= 4 && r <= 7) m_out[r-4] = d;
            if (r == 8 || r == 9) m_scr[r-8] = d;
            if (r >= 10 && r <= 12) m_target[r-10] = (d == 8'h00) ? 256 : int'(d);
        end
        if (hw) m_in[ha] = hd;
    endtask

    // One bus cycle; entered and left at posedge+1.
    task automatic cyc(input logic ce, input logic [15:0] a, input logic [7:0] d,
                       input logic we_n, input logic hw, input logic [1:0] ha,
                       input logic [7:0] hd, input logic [7:0] di);
        bus.ce = ce; bus.a_in = a; bus.d_in = d; bus.we_n = we_n;
        host_wr = hw; host_addr = ha; host_din = hd; dsp_di = di;
        @(negedge clk);
        chk("sel", {7'b0, bus.sel}, {7'b0, a[15:4] == 12'h00F});
        chk("d_out", bus.d_out, m_read(a, di));
        chk("host_dout", host_dout, m_out[ha]);
        model_edge(ce, a, d, we_n, hw, ha, hd);
        @(posedge clk);
        #1;
        chk("dsp_addr", dsp_addr, m_dsp_addr);
        chk("dsp_do", dsp_do, m_dsp_do);
        chk("dsp_we", {7'b0, dsp_we}, {7'b0, m_dsp_we});
        chk("ipl_en", {7'b0, ipl_en}, {7'b0, m_ctrl[7]});
    endtask

    task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d);
        cyc(1'b1, a, d, 1'b0, 1'b0, 2'd0, 8'h00, 8'h00);
    endtask

    task automatic cpu_rd(input logic [15:0] a);
        cyc(1'b1, a, 8'h00, 1'b1, 1'b0, 2'd0, 8'h00, 8'h00);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 16'h0000, 8'h00, 1'b1, 1'b0, 2'd0, 8'h00, 8'h00);
    endtask

    task automatic align_t2();
        for (int i = 0; i < T2 && ((m_ce + 1) % T2) != 0; i++) idle(1);
    endtask

    task automatic mid_reset();
        bus.ce = 1'b0;
        host_wr = 1'b0;
        rst_n = 1'b0;
        #3;
        chk("rst_ipl_en", {7'b0, ipl_en}, 8'h01);
        chk("rst_dsp_addr", dsp_addr, 8'h00);
        chk("rst_dsp_we", {7'b0, dsp_we}, 8'h00);
        chk("rst_host_dout", host_dout, 8'h00);
        reset_model();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.ce = 1'b0; bus.a_in = 16'h0000; bus.d_in = 8'h00; bus.we_n = 1'b1;
        host_wr = 1'b0; host_addr = 2'd0; host_din = 8'h00; dsp_di = 8'h00;
        reset_model();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset state
        cpu_rd(16'h00F1);
        cpu_rd(16'h00FA);
        cpu_rd(16'h00FD);

        // Timer 2, target 4
        cpu_wr(16'h00FC, 8'h04);
        cpu_wr(16'h00F1, 8'h84);
        idle(64);
        cpu_rd(16'h00FF);
        cpu_rd(16'h00FF);

        // CE stall freezes timing
        for (int i = 0; i < 40; i++) cyc(1'b0, 16'h00FF, 8'h00, 1'b1, 1'b0, 2'd0, 8'h00, 8'h00);
        cpu_rd(16'h00FF);

        // Enable coincident with a base tick, then read at an increment
        cpu_wr(16'h00F1, 8'h80);
        cpu_wr(16'h00FC, 8'h01);
        align_t2();
        cpu_wr(16'h00F1, 8'h84);
        idle(T2 - 1);
        cpu_rd(16'h00FF);
        cpu_rd(16'h00FF);

        // Timer 0, target 256
        cpu_wr(16'h00FA, 8'h00);
        cpu_wr(16'h00F1, 8'h01);
        idle(T01 * 256);
        cpu_rd(16'h00FD);

        // Host and port traffic
        cyc(1'b0, 16'h0000, 8'h00, 1'b1, 1'b1, 2'd1, 8'h5A, 8'h00);
        cpu_rd(16'h00F5);
        cyc(1'b1, 16'h00F6, 8'hC3, 1'b0, 1'b0, 2'd2, 8'h00, 8'h00);
        cyc(1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 2'd2, 8'h00, 8'h00);
        cpu_wr(16'h00F1, 8'h10);
        cpu_rd(16'h00F5);
        cyc(1'b1, 16'h00F1, 8'h30, 1'b0, 1'b1, 2'd3, 8'hA7, 8'h00);
        cpu_rd(16'h00F7);
        cpu_wr(16'h00F8, 8'h12);
        cpu_wr(16'h00F9, 8'h34);
        cpu_rd(16'h00F8);
        cpu_rd(16'h00F9);

        // DSP passthrough
        cpu_wr(16'h00F2, 8'h6C);
        cpu_wr(16'h00F3, 8'hE0);
        idle(1);
        cyc(1'b1, 16'h00F3, 8'h00, 1'b1, 1'b0, 2'd0, 8'h00, 8'h3F);
        cpu_rd(16'h00F2);

        // Timer 1 counts to 15, then wraps
        cpu_wr(16'h00FB, 8'h01);
        cpu_wr(16'h00F1, 8'h02);
        idle(T01 * 15);
        cpu_rd(16'h00FE);
        cpu_wr(16'h00F1, 8'h00);
        cpu_wr(16'h00F1, 8'h02);
        idle(T01 * 16);
        cpu_rd(16'h00FE);

        // Reset mid-count
        cpu_wr(16'h00FC, 8'h01);
        cpu_wr(16'h00F1, 8'h07);
        cpu_wr(16'h00F2, 8'h55);
        idle(3 * T2);
        mid_reset();
        idle(3 * T2);
        cpu_rd(16'h00FD);
        cpu_rd(16'h00FE);
        cpu_rd(16'h00FF);
        cpu_rd(16'h00F2);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            logic [15:0] a;
            logic [7:0]  d;
            if ($urandom_range(0, 3) != 0) a = {12'h00F, 4'($urandom_range(0, 15))};
            else a = 16'($urandom);
            d = 8'($urandom);
            if (a == 16'h00FA || a == 16'h00FB || a == 16'h00FC) d = 8'($urandom_range(1, 4));
            cyc($urandom_range(0, 3) != 0, a, d, $urandom_range(0, 2) != 0,
                $urandom_range(0, 4) == 0, 2'($urandom_range(0, 3)), 8'($urandom),
                8'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/spc700_io_regs.md
# spc700_io_regs

Bus responder for the SPC700 core's data bus. It decodes the CPU's $00F0-$00FF I/O window and implements:
- TEST/CONTROL registers
- DSP address/data passthrough
- the four host mailbox ports
- two scratch registers
- three interval timers with 4-bit read-to-clear outputs

It sits between the CPU's address/data/write-strobe outputs and the audio RAM read mux, and also faces the main CPU (host) side of the mailbox.

## Interface
Parameters:
- T01_DIV, 128, CE ticks per timer 0/1 base tick
- T2_DIV, 16, CE ticks per timer 2 base tick

Ports:
- CLK  in  1  system clock
- RST_N  in  1  reset; asynchronous, active-low
- CE  in  1  one-cycle strobe marking a completed CPU bus cycle (CPU enabled)
- A_IN  in  16  CPU address
- D_IN  in  8  CPU write data
- WE_N  in  1  CPU write strobe, active low
- D_OUT  out  8  read data for the current address, combinational
- SEL  out  1  high when A_IN[15:4]==12'h00F; the RAM mux selects D_OUT
- IPL_EN  out  1  CONTROL[7]; the boot ROM overlays $FFC0-$FFFF
- DSP_ADDR  out  8  $F2 register
- DSP_DO  out  8  data of the last $F3 write
- DSP_WE  out  1  one-cycle pulse on a $F3 write
- DSP_DI  in  8  DSP register read data
- HOST_ADDR  in  2  host port select
- HOST_WR  in  1  host write strobe, one cycle
- HOST_DIN  in  8  host write data
- HOST_DOUT  out  8  SPC-written output port [HOST_ADDR], combinational

## Operation
- Access rule: an access occurs only in a cycle with CE=1 and SEL=1.
  - WE_N=0 means a write; it takes effect at the clock edge.
  - WE_N=1 means a read; read side effects also occur at that edge.
- Register map, with reset values:
  - $F0 TEST: write-only, stored and unused; reads 0x00. Reset 0x0A.
  - $F1 CONTROL: write-only; reads 0x00. Reset 0xB0.
    - bits 2:0 enable timers 2:0.
    - bit 4 set on write clears input ports 0,1.
    - bit 5 set on write clears input ports 2,3.
    - bit 7 drives IPL_EN.
  - $F2: read/write DSP_ADDR. Reset 0x00.
  - $F3: reads return DSP_DI. A write loads DSP_DO and pulses DSP_WE for exactly one cycle.
  - $F4-$F7: reads return input port n (written by the host). Writes load output port n (drives HOST_DOUT). All ports reset to 0x00.
  - $F8/$F9: plain read/write scratch registers. Reset 0x00.
  - $FA-$FC: write-only timer targets; reads 0x00. Reset 0x00. Target 0x00 means 256.
  - $FD-$FF: read-only 4-bit counter outputs, returned as {4'h0, cnt}. A read clears the counter. Writes are ignored.
- Timers (n=0..2):
  - A free-running prescaler counts CE cycles regardless of enable. It emits a base tick every T01_DIV CEs (timers 0/1) or every T2_DIV CEs (timer 2).
  - While the timer is enabled, each base tick increments an 8-bit stage counter.
  - When the incremented value equals the target (8-bit compare, 256 ≡ 0 after wrap), the stage resets to 0 and the output counter increments. The output counter wraps 15→0.
  - A 0→1 transition of the enable bit clears both the stage and output counters for that timer. Writing 1 over an existing 1 has no effect.
  - A 1→0 transition freezes both counters; their values are retained.
- Host side: HOST_WR loads input port [HOST_ADDR] with HOST_DIN on the edge. It is not gated by CE.
- Simultaneous events:
  - Host write to port p and a CONTROL clear of p in the same cycle: the host write wins.
  - Read of $FD-$FF in the same cycle as that counter's increment: D_OUT shows the pre-increment value, and the counter becomes 1.
  - A write to CONTROL that enables a timer in the same cycle as that timer's base tick: the clear wins, and the counters are 0 afterwards.
- Reset mid-operation: every register, prescaler, stage and output counter returns to its reset value immediately. DSP_WE deasserts.

## Timing
- D_OUT, SEL and HOST_DOUT are combinational; there is zero-cycle read latency.
- D_OUT is 0x00 whenever SEL=0.
- Write-through latency is one edge:
  - register outputs (DSP_ADDR, IPL_EN, HOST_DOUT) reflect a write in the cycle after the write edge.
  - DSP_WE is high in that same following cycle only.
- Output counter visible latency: a counter increments on the edge of the CE cycle whose base tick reaches the target. It is readable from the next cycle.
- Prescalers advance only on CE; stalled CPU cycles (CE=0) freeze all timing.
- Reset values of outputs:
  - D_OUT 0x00, because SEL follows A_IN.
  - IPL_EN 1.
  - DSP_ADDR 0x00, DSP_DO 0x00, DSP_WE 0.
  - HOST_DOUT 0x00.

## Test plan
- Reset, then read $F1, $FA and $FD with CE → each returns 0x00; IPL_EN=1, DSP_ADDR=0x00.
- Set up timer 2:
  - Write $FC=0x04, then write $F1=0x84 (enable timer 2).
  - Apply 64 CEs, then read $FF → 0x01.
  - Immediately read $FF again → 0x00.
- Set up timer 0:
  - Write $FA=0x00 (target 256), then write $F1=0x01.
  - Apply 128×256 CEs, then read $FD → 0x01.
- Host/port traffic:
  - Host writes port 1=0x5A → CPU read of $F5 returns 0x5A.
  - CPU writes $F6=0xC3 → HOST_DOUT with HOST_ADDR=2 is 0xC3.
  - CPU writes $F1=0x10 → a read of $F5 returns 0x00.
- DSP passthrough:
  - Write $F2=0x6C, then write $F3=0xE0 → DSP_ADDR=0x6C, DSP_DO=0xE0, DSP_WE high for one cycle.
  - With DSP_DI=0x3F, a read of $F3 returns 0x3F.
- Counter boundary and reset:
  - Drive the timer 1 output counter to 15, then apply one more target hit → reads 0x00.
  - Separately, assert RST_N=0 mid-count → all counters are 0 and CONTROL=0xB0 after release.
